cnt_job_master: RTL and testbench
=================================

# cnt_job_master

Initiator-side sequencer for the counter start/done handshake. It buffers count jobs from upstream logic and issues each one to a counter subsystem as a `start_o` pulse with a stable `cnt_val_o`. It then waits for that subsystem's `done` and reports per-job completion with the measured cycle count. It sits between a job producer and a counter top, and drives the counter top's `start_i`/`cnt_val_i` and consumes its `done_o`.

## Interface
- `DWIDTH`, 7: width of job value / `cnt_val_o`.
- `DEPTH`, 4: job FIFO entries (power of 2, ≥2).
- `CWIDTH`, 16: width of elapsed-cycle measurement.
- `TIMEOUT`, 256: watchdog limit in WAIT cycles (used only with `CNT_JOB_TIMEOUT_EN`).
- `clk`  in  1  clock; all logic rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `job_valid_i`  in  1  upstream job offered.
- `job_val_i`  in  DWIDTH  count target of offered job.
- `job_ready_o`  out  1  FIFO can accept; transfer on `job_valid_i & job_ready_o`.
- `start_o`  out  1  one-cycle start pulse to counter subsystem.
- `cnt_val_o`  out  DWIDTH  target of current job; held from issue until next issue.
- `done_i`  in  1  completion from counter subsystem (pulse or level accepted).
- `busy_o`  out  1  high in ISSUE/WAIT/DONE.
- `res_valid_o`  out  1  one-cycle result strobe.
- `res_val_o`  out  DWIDTH  job value of reported result.
- `res_cycles_o`  out  CWIDTH  cycles from `start_o` to accepted `done_i`.
- `err_o`  out  1  qualifies `res_valid_o`: job aborted by timeout.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: FIFO non-empty → pop head into `cnt_val_o`/`res_val_o` register, clear cycle counter and `seen_low` flag, → ISSUE.
- ISSUE: `start_o`=1 (Moore, exactly one cycle); → WAIT.
- WAIT: cycle counter +1 per cycle, saturating at 2^CWIDTH−1. `done_i`=0 sets `seen_low`. `done_i`=1 with `seen_low` set → DONE. `done_i` high without a prior low in this WAIT is ignored, so a level-style done held over from the previous job is never mis-accepted.
- DONE: `res_valid_o`=1, `err_o`=0; → IDLE.
- `done_i` outside WAIT: ignored.
- Job value 0: issued unchanged; no special case.
- FIFO: `job_ready_o` = !full (registered count). Push and pop in the same cycle are legal when not full; count unchanged. When full, no push, even if a pop occurs that cycle.
- Reset at any point: FIFO emptied, FSM → IDLE, in-flight job dropped without a result.
- Reset values: `start_o`, `busy_o`, `res_valid_o`, `err_o`, `cnt_val_o`, `res_val_o`, `res_cycles_o` all 0; `job_ready_o` 1.

## Timing
- Job accepted at edge E0 with FSM in IDLE → `start_o` high in the cycle after E1 (2-cycle latency).
- `res_cycles_o` = number of WAIT cycles up to and including the cycle in which `done_i` is accepted. Minimum value 2, because one low sample is needed first.
- `res_valid_o` occurs one cycle after done acceptance.
- Back-to-back jobs: each job occupies at least ISSUE + 2 WAIT + DONE + IDLE = 5 cycles.
- All outputs are registered; no combinational path from input to output except `job_ready_o`, which depends only on state.

## Configuration
- `CNT_JOB_TIMEOUT_EN` defined: in WAIT, once cycle counter reaches `TIMEOUT`, → DONE with `err_o`=1 and `res_cycles_o`=`TIMEOUT`. A `done_i` arriving in that same cycle takes priority, giving a normal result.
- Not defined: WAIT has no limit; `err_o` is tied to 0; `TIMEOUT` is unused.

## Structure
- Package `cnt_job_pkg`: FSM state enum (`S_IDLE`, `S_ISSUE`, `S_WAIT`, `S_DONE`), default constants for `DEPTH`/`CWIDTH`/`TIMEOUT`.
- Sub-module `cnt_job_fifo`: synchronous FIFO (parameters DWIDTH, DEPTH; push/pop/full/empty/count). The FSM, cycle counter and result registers live in `cnt_job_master`.

## Test plan
- Single job 5; responder pulses `done_i` 6 cycles after `start_o` → one `start_o` pulse, `cnt_val_o`=5, `res_valid_o` with `res_val_o`=5, `res_cycles_o`=6, `err_o`=0.
- Push 5 jobs (1,2,3,4,5) with no pops, DEPTH=4 → `job_ready_o` falls after the 4th accepted. The 5th is held until a pop, and all 5 results appear in order.
- `done_i` held high as a level until the next `start_o` → the next job is not completed until `done_i` drops and rises again, and its `res_cycles_o` is ≥2.
- Assert `rst` during WAIT with 2 jobs queued → the next cycle shows `busy_o`=0 and `job_ready_o`=1; no `res_valid_o` and no further `start_o`.
- With `CNT_JOB_TIMEOUT_EN`, TIMEOUT=8, `done_i` never asserted → `res_valid_o` with `err_o`=1, `res_cycles_o`=8, then the next queued job is issued.
- Push and pop in the same cycle with count=2 → count stays 2, and data order is preserved.

Source files
------------

// File: rtl/cnt_job_pkg.sv
// Shared types and default parameters for the counter job sequencer.
// Imported by cnt_job_fifo and cnt_job_master.
package cnt_job_pkg;

    localparam int DWIDTH_DEF  = 7;
    localparam int DEPTH_DEF   = 4;
    localparam int CWIDTH_DEF  = 16;
    localparam int TIMEOUT_DEF = 256;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/cnt_job_fifo.sv
// Synchronous job FIFO with a registered occupancy count; first-word
// fall-through read of the head entry.
module cnt_job_fifo
    import cnt_job_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [DWIDTH-1:0]            push_data,
    input  logic                         pop,
    output logic [DWIDTH-1:0]            pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("cnt_job_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    // A push is refused while full even if a pop happens in the same cycle.
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // NOTE: storage carries no reset; only pointers and count define validity,
    // which keeps the array a plain RAM with no reset fan-out.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: every sequential assignment uses <= so all registers update from
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cnt_job_master.sv
// Initiator for the counter start/done handshake: queues jobs, issues them,
// measures completion time. Optional watchdog: define CNT_JOB_TIMEOUT_EN.
module cnt_job_master
    import cnt_job_pkg::*;
#(
    parameter int DWIDTH  = DWIDTH_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int CWIDTH  = CWIDTH_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              job_valid_i,
    input  logic [DWIDTH-1:0] job_val_i,
    output logic              job_ready_o,
    output logic              start_o,
    output logic [DWIDTH-1:0] cnt_val_o,
    input  logic              done_i,
    output logic              busy_o,
    output logic              res_valid_o,
    output logic [DWIDTH-1:0] res_val_o,
    output logic [CWIDTH-1:0] res_cycles_o,
    output logic              err_o
);

    if ((TIMEOUT < 2) || (CWIDTH < 31 && TIMEOUT >= (1 << CWIDTH))) begin : g_bad_timeout
        $error("cnt_job_master: TIMEOUT must be at least 2 and fit in CWIDTH bits");
    end

    state_t                     state;
    state_t                     state_next;
    logic                       fifo_pop;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [DWIDTH-1:0]          fifo_data;
    logic [$clog2(DEPTH+1)-1:0] unused_fifo_count;

    logic [DWIDTH-1:0]          job_val;
    logic [CWIDTH-1:0]          cyc;
    logic [CWIDTH-1:0]          cyc_inc;
    logic [CWIDTH-1:0]          res_cycles;
    logic                       seen_low;
    logic                       done_accept;
    logic                       timeout_hit;

    cnt_job_fifo #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (job_valid_i),
        .push_data (job_val_i),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (unused_fifo_count)
    );

    assign job_ready_o = !fifo_full;

    // Saturating elapsed-cycle count for the current WAIT cycle.
    assign cyc_inc = (cyc == '1) ? cyc : cyc + 1'b1;

    // A done level left over from the previous job must drop once before it counts.
    assign done_accept = (state == S_WAIT) && done_i && seen_low;

`ifdef CNT_JOB_TIMEOUT_EN
    assign timeout_hit = (state == S_WAIT) && !done_accept && (cyc_inc >= CWIDTH'(TIMEOUT));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: each always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (!fifo_empty) state_next = S_ISSUE;
            S_ISSUE: state_next = S_WAIT;
            S_WAIT:  if (done_accept || timeout_hit) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        start_o     = 1'b0;
        busy_o      = 1'b1;
        res_valid_o = 1'b0;
        fifo_pop    = 1'b0;
        unique case (state)
            S_IDLE: begin
                busy_o   = 1'b0;
                fifo_pop = !fifo_empty;
            end
            S_ISSUE: start_o     = 1'b1;
            S_WAIT:  start_o     = 1'b0;
            S_DONE:  res_valid_o = 1'b1;
            default: busy_o      = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            job_val    <= '0;
            cyc        <= '0;
            seen_low   <= 1'b0;
            res_cycles <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        job_val  <= fifo_data;
                        cyc      <= '0;
                        seen_low <= 1'b0;
                    end
                end
                S_WAIT: begin
                    cyc <= cyc_inc;
                    if (!done_i) begin
                        seen_low <= 1'b1;
                    end
                    if (state_next == S_DONE) begin
                        res_cycles <= cyc_inc;
                    end
                end
                default: begin
                    cyc <= cyc;
                end
            endcase
        end
    end

    assign cnt_val_o    = job_val;
    assign res_val_o    = job_val;
    assign res_cycles_o = res_cycles;

`ifdef CNT_JOB_TIMEOUT_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state == S_WAIT && state_next == S_DONE) begin
            err_q <= timeout_hit;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_cnt_job_master.sv
// Directed bench for cnt_job_master: pulse/level responders, FIFO fill,
// same-cycle push/pop, reset mid-job and (with CNT_JOB_TIMEOUT_EN) watchdog.
module tb_cnt_job_master;

    localparam int DWIDTH  = 7;
    localparam int DEPTH   = 4;
    localparam int CWIDTH  = 16;
    localparam int TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              job_valid_i = 1'b0;
    logic [DWIDTH-1:0] job_val_i = '0;
    logic              job_ready_o;
    logic              start_o;
    logic [DWIDTH-1:0] cnt_val_o;
    logic              done_i = 1'b0;
    logic              busy_o;
    logic              res_valid_o;
    logic [DWIDTH-1:0] res_val_o;
    logic [CWIDTH-1:0] res_cycles_o;
    logic              err_o;

    cnt_job_master #(
        .DWIDTH  (DWIDTH),
        .DEPTH   (DEPTH),
        .CWIDTH  (CWIDTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .job_valid_i  (job_valid_i),
        .job_val_i    (job_val_i),
        .job_ready_o  (job_ready_o),
        .start_o      (start_o),
        .cnt_val_o    (cnt_val_o),
        .done_i       (done_i),
        .busy_o       (busy_o),
        .res_valid_o  (res_valid_o),
        .res_val_o    (res_val_o),
        .res_cycles_o (res_cycles_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Result and start monitor, sampled mid-cycle.
    typedef struct {
        logic [DWIDTH-1:0] val;
        logic [CWIDTH-1:0] cyc;
        logic              err;
    } res_t;

    res_t res_q[$];
    int   start_cnt = 0;

    always @(negedge clk) begin
        if (start_o) start_cnt++;
        if (res_valid_o) res_q.push_back('{res_val_o, res_cycles_o, err_o});
    end

    // done responder: NONE never answers, PULSE answers delay cycles after start,
    // LEVEL raises and holds done, dropping it hold cycles into the next job.
    typedef enum int {R_NONE, R_PULSE, R_LEVEL} rmode_t;
    rmode_t rmode      = R_NONE;
    int     resp_delay = 6;
    int     resp_hold  = 3;
    int     rcnt       = 0;
    int     lphase     = 0;

    always @(negedge clk) begin
        case (rmode)
            R_NONE: begin
                done_i = 1'b0;
                rcnt   = 0;
                lphase = 0;
            end
            R_PULSE: begin
                done_i = 1'b0;
                lphase = 0;
                if (rcnt > 0) begin
                    rcnt--;
                    if (rcnt == 0) done_i = 1'b1;
                end
                if (start_o) rcnt = resp_delay;
            end
            default: begin
                if (start_o) begin
                    if (done_i) begin
                        lphase = 1;
                        rcnt   = resp_hold;
                    end else begin
                        lphase = 2;
                        rcnt   = resp_delay;
                    end
                end else if (lphase != 0) begin
                    rcnt--;
                    if (rcnt == 0) begin
                        if (lphase == 1) begin
                            done_i = 1'b0;
                            lphase = 2;
                            rcnt   = resp_delay;
                        end else begin
                            done_i = 1'b1;
                            lphase = 0;
                        end
                    end
                end
            end
        endcase
    end

    task automatic push_job(input logic [DWIDTH-1:0] v);
        bit acc = 1'b0;
        job_valid_i = 1'b1;
        job_val_i   = v;
        for (int i = 0; i < 300; i++) begin
            acc = job_ready_o;
            @(negedge clk);
            if (acc) break;
        end
        job_valid_i = 1'b0;
        if (!acc) check("push_accept", 32'(acc), 32'd1);
    endtask

    task automatic wait_start(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (start_o) break;
        end
        check("wait_start", 32'(start_o), 32'd1);
    endtask

    task automatic wait_res(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (res_q.size() >= n) break;
            @(negedge clk);
        end
        check("res_count", 32'(res_q.size()), 32'(n));
    endtask

    task automatic check_res(input string tag, input int idx, input logic [DWIDTH-1:0] val,
                             input int cyc, input logic err);
        if (idx < res_q.size()) begin
            check({tag, "_val"}, 32'(res_q[idx].val), 32'(val));
            check({tag, "_cyc"}, 32'(res_q[idx].cyc), 32'(cyc));
            check({tag, "_err"}, 32'(res_q[idx].err), 32'(err));
        end else begin
            check({tag, "_present"}, 32'(res_q.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_s;
        int base_r;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_start", 32'(start_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_res_valid", 32'(res_valid_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_cnt_val", 32'(cnt_val_o), 32'd0);
        check("rst_res_val", 32'(res_val_o), 32'd0);
        check("rst_res_cycles", 32'(res_cycles_o), 32'd0);
        check("rst_ready", 32'(job_ready_o), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Single job 5, done pulsed 6 cycles after start; 2-cycle issue latency
        rmode      = R_PULSE;
        resp_delay = 6;
        push_job(7'd5);
        check("t1_no_start_yet", 32'(start_o), 32'd0);
        @(negedge clk);
        check("t1_start", 32'(start_o), 32'd1);
        check("t1_cnt_val", 32'(cnt_val_o), 32'd5);
        @(negedge clk);
        check("t1_start_one_cycle", 32'(start_o), 32'd0);
        check("t1_busy", 32'(busy_o), 32'd1);
        wait_res(1, 50);
        check_res("t1", 0, 7'd5, 6, 1'b0);
        check("t1_starts", 32'(start_cnt), 32'd1);
        repeat (3) @(negedge clk);

        // FIFO fill: FSM busy on 0x40, jobs 1..4 fill FIFO, 5 waits for a pop
        resp_delay = 20;
        base_s = start_cnt;
        base_r = res_q.size();
        push_job(7'h40);
        for (int j = 1; j <= 4; j++) push_job(7'(j));
        check("t2_ready_full", 32'(job_ready_o), 32'd0);
        push_job(7'd5);
        check("t2_held_until_pop", 32'(start_cnt - base_s), 32'd2);
        wait_res(base_r + 6, 400);
        check_res("t2_r0", base_r, 7'h40, 20, 1'b0);
        for (int j = 1; j <= 5; j++) check_res("t2_rn", base_r + j, 7'(j), 20, 1'b0);
        repeat (3) @(negedge clk);

        // Level done: held over from job 9 into job 10
        rmode      = R_LEVEL;
        resp_delay = 2;
        resp_hold  = 3;
        base_r = res_q.size();
        push_job(7'd9);
        push_job(7'd10);
        wait_res(base_r + 2, 100);
        check_res("t3_first", base_r, 7'd9, 2, 1'b0);
        check_res("t3_level", base_r + 1, 7'd10, 5, 1'b0);
        rmode = R_PULSE;
        repeat (3) @(negedge clk);

        // Same-cycle push and pop with count 2
        resp_delay = 10;
        base_r = res_q.size();
        push_job(7'h11);
        wait_start(20);
        push_job(7'h12);
        push_job(7'h13);
        repeat (10) @(negedge clk);
        check("t4_count_before", 32'(dut.u_fifo.count), 32'd2);
        job_valid_i = 1'b1;
        job_val_i   = 7'h14;
        @(negedge clk);
        job_valid_i = 1'b0;
        check("t4_count_after", 32'(dut.u_fifo.count), 32'd2);
        check("t4_next_start", 32'(start_o), 32'd1);
        check("t4_next_val", 32'(cnt_val_o), 32'h12);
        wait_res(base_r + 4, 200);
        for (int j = 0; j < 4; j++) check_res("t4_order", base_r + j, 7'(8'h11 + j), 10, 1'b0);
        repeat (3) @(negedge clk);

        // Reset during WAIT with two jobs queued
        resp_delay = 30;
        push_job(7'h21);
        wait_start(20);
        push_job(7'h22);
        push_job(7'h23);
        repeat (3) @(negedge clk);
        base_s = start_cnt;
        base_r = res_q.size();
        rst = 1'b1;
        @(negedge clk);
        check("t5_busy", 32'(busy_o), 32'd0);
        check("t5_ready", 32'(job_ready_o), 32'd1);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        check("t5_no_start", 32'(start_cnt), 32'(base_s));
        check("t5_no_result", 32'(res_q.size()), 32'(base_r));

`ifdef CNT_JOB_TIMEOUT_EN
        // Watchdog, then done arriving on the timeout cycle wins
        rmode  = R_NONE;
        base_r = res_q.size();
        push_job(7'h33);
        push_job(7'h34);
        wait_res(base_r + 1, 100);
        check_res("t6_timeout", base_r, 7'h33, TIMEOUT, 1'b1);
        resp_delay = TIMEOUT;
        rmode      = R_PULSE;
        wait_res(base_r + 2, 100);
        check_res("t6_done_wins", base_r + 1, 7'h34, TIMEOUT, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
